// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - SPI master shared by two requesters through a round-robin arbiter
module spi_master_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req,
   input  logic [DATA_WIDTH-1:0] tx_data0,
   input  logic [DATA_WIDTH-1:0] tx_data1,
   output logic [1:0]            gnt,
   output logic [1:0]            done,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  busy,
   output logic                  sclk,
   output logic                  cs_n,
   output logic                  mosi,
   input  logic                  miso
);

   localparam int CNT_W = $clog2(CLK_DIV) + 1;
   localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_XFER,
      S_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [1:0]            gnt_q, gnt_d;
   logic [1:0]            done_q, done_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_n_q, cs_n_d;
   logic                  mosi_q, mosi_d;
   logic                  ptr_q, ptr_d;
   logic                  pick1;
   logic [DATA_WIDTH-1:0] win_data;

   // ptr_q holds the last granted requester; on a tie the other one wins.
   always_comb begin
      pick1    = (req == 2'b11) ? ~ptr_q : req[1];
      win_data = pick1 ? tx_data1 : tx_data0;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      gnt_d     = gnt_q;
      done_d    = 2'b00;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      mosi_d    = mosi_q;
      ptr_d     = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_SETUP;
               ptr_d   = pick1;
               gnt_d   = pick1 ? 2'b10 : 2'b01;
               tx_d    = win_data;
               mosi_d  = win_data[0];
               cs_n_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         S_SETUP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               sclk_d  = 1'b1;
               state_d = S_XFER;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_XFER: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (sclk_q) begin
                  // Falling edge: capture MISO and present the next TX bit.
                  sclk_d = 1'b0;
                  rx_d   = {rx_q[DATA_WIDTH-2:0], miso};
                  tx_d   = tx_q >> 1;
                  mosi_d = tx_q[1];
                  if (bit_q == BIT_LAST) begin
                     state_d = S_HOLD;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end else begin
                  sclk_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               state_d   = S_IDLE;
               cs_n_d    = 1'b1;
               gnt_d     = 2'b00;
               mosi_d    = 1'b0;
               rx_data_d = rx_q;
               done_d    = gnt_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
         ptr_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         mosi_q    <= mosi_d;
         ptr_q     <= ptr_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign busy    = (state_q != S_IDLE);
   assign sclk    = sclk_q;
   assign cs_n    = cs_n_q;
   assign mosi    = mosi_q;

endmodule
